// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: opcodes, NOP encoding and the hazard FSM states.
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // addi x0, x0, 0 -- what a flushed pipeline register holds
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int REG_IDX_W = 5;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DIV_BUSY = 2'd2
    } hz_state_e;

    function automatic logic is_load_use(input logic     mem_read,
                                         input reg_idx_t rd,
                                         input reg_idx_t rs1,
                                         input reg_idx_t rs2);
        return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_lat_counter.sv
// Loadable down-counter that times the E-stage divider; stops at zero.
module lat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory waits and
// multi-cycle divide stalls, plus a saturating stall-cycle performance counter.
module hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             mem_read_e,
    input  logic             branch_taken_e,
    input  logic             div_start_e,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             div_done_e,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [7:0] DIV_LOAD_VAL = 8'(DIV_LATENCY - 1);

    hz_state_e state;
    logic      mem_wait;
    logic      load_use;
    logic      div_load;
    logic      div_dec;
    logic      div_zero;

    assign mem_wait = mem_req_m && !mem_ready_m;
    assign load_use = is_load_use(mem_read_e, rd_e, rs1_d, rs2_d);
    assign div_load = (state == ST_RUN) && !mem_wait && div_start_e;
    assign div_dec  = (state == ST_DIV_BUSY) && !div_zero;

    lat_counter #(.W(8)) u_div_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (div_load),
        .load_val (DIV_LOAD_VAL),
        .dec      (div_dec),
        .zero     (div_zero)
    );

    // Outputs are combinational from state and inputs so a bubble lands in the same cycle;
    // reset forces them low regardless of what the pipeline presents.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        div_done_e = 1'b0;
        if (!rst_i) begin
            unique case (state)
                ST_RUN: begin
                    if (mem_wait) begin
                        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    end else if (div_start_e) begin
                        {stall_f, stall_d, stall_e} = 3'b111;
                    end else if (branch_taken_e) begin
                        {flush_d, flush_e} = 2'b11;
                    end else if (load_use) begin
                        {stall_f, stall_d, flush_e} = 3'b111;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready_m) begin
                        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    end
                end
                ST_DIV_BUSY: begin
                    if (div_zero) begin
                        div_done_e = 1'b1;
                    end else begin
                        {stall_f, stall_d, stall_e} = 3'b111;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_RUN;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (mem_wait) begin
                        state <= ST_MEM_WAIT;
                    end else if (div_start_e) begin
                        state <= ST_DIV_BUSY;
                    end
                end
                ST_MEM_WAIT: if (mem_ready_m) state <= ST_RUN;
                ST_DIV_BUSY: if (div_zero)    state <= ST_RUN;
                default:                      state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_f && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: single-cycle vector table, multi-cycle
// sequences and a randomized run against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int DL    = 4;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    // Output pattern order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, div_done_e}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100010;
    localparam logic [6:0] O_BR   = 7'b0000110;
    localparam logic [6:0] O_MEM  = 7'b1111000;
    localparam logic [6:0] O_DIV  = 7'b1110000;
    localparam logic [6:0] O_DONE = 7'b0000001;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       ds;
        logic       mreq;
        logic       mrdy;
        logic [6:0] exp;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [4:0]    rs1_d = '0, rs2_d = '0, rd_e = '0;
    logic          mem_read_e = 1'b0, branch_taken_e = 1'b0, div_start_e = 1'b0;
    logic          mem_req_m = 1'b0, mem_ready_m = 1'b0;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, div_done_e;
    logic [CW-1:0] stall_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.DIV_LATENCY(DL), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rd_e           (rd_e),
        .mem_read_e     (mem_read_e),
        .branch_taken_e (branch_taken_e),
        .div_start_e    (div_start_e),
        .mem_req_m      (mem_req_m),
        .mem_ready_m    (mem_ready_m),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .div_done_e     (div_done_e),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] outs();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, div_done_e};
    endfunction

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic mr, input logic bt, input logic ds,
                                input logic mreq, input logic mrdy, input logic [6:0] exp);
        vec_t v;
        v = '{rs1: rs1, rs2: rs2, rd: rd, mr: mr, bt: bt, ds: ds, mreq: mreq, mrdy: mrdy, exp: exp};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_d          = v.rs1;
        rs2_d          = v.rs2;
        rd_e           = v.rd;
        mem_read_e     = v.mr;
        branch_taken_e = v.bt;
        div_start_e    = v.ds;
        mem_req_m      = v.mreq;
        mem_ready_m    = v.mrdy;
    endtask

    // Drive one cycle, compare outputs at the falling edge, then step past the rising edge.
    task automatic step(input string name, input vec_t v);
        drive(v);
        @(negedge clk_i);
        check(name, 32'(outs()), 32'(v.exp));
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive('0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Reference model: whether a memory wait is outstanding and how many divide
    // stall cycles remain before the done cycle (-1 when no divide is in flight).
    bit m_mem;
    int m_div_left;
    int m_cnt;

    function automatic logic [6:0] model_out(input vec_t v);
        logic lu;
        lu = v.mr && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2);
        if (m_mem)                return v.mrdy ? O_NONE : O_MEM;
        if (m_div_left >= 0)      return (m_div_left == 0) ? O_DONE : O_DIV;
        if (v.mreq && !v.mrdy)    return O_MEM;
        if (v.ds)                 return O_DIV;
        if (v.bt)                 return O_BR;
        if (lu)                   return O_LU;
        return O_NONE;
    endfunction

    task automatic model_advance(input vec_t v, input logic [6:0] o, input logic rst);
        if (rst) begin
            m_mem = 0; m_div_left = -1; m_cnt = 0;
        end else begin
            if (o[6] && m_cnt < CMAX) m_cnt++;
            if (m_mem) begin
                if (v.mrdy) m_mem = 0;
            end else if (m_div_left >= 0) begin
                m_div_left = (m_div_left == 0) ? -1 : m_div_left - 1;
            end else if (v.mreq && !v.mrdy) begin
                m_mem = 1;
            end else if (v.ds) begin
                m_div_left = DL - 1;
            end
        end
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(5'd5,  5'd0,  5'd5,  1, 0, 0, 0, 0, O_LU);
        tbl[1]  = mk(5'd0,  5'd0,  5'd0,  1, 0, 0, 0, 0, O_NONE);
        tbl[2]  = mk(5'd3,  5'd5,  5'd5,  1, 0, 0, 0, 0, O_LU);
        tbl[3]  = mk(5'd5,  5'd0,  5'd5,  0, 0, 0, 0, 0, O_NONE);
        tbl[4]  = mk(5'd5,  5'd6,  5'd7,  1, 0, 0, 0, 0, O_NONE);
        tbl[5]  = mk(5'd5,  5'd0,  5'd5,  1, 1, 0, 0, 0, O_BR);
        tbl[6]  = mk(5'd0,  5'd0,  5'd0,  0, 1, 0, 0, 0, O_BR);
        tbl[7]  = mk(5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 0, O_MEM);
        tbl[8]  = mk(5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 1, O_NONE);
        tbl[9]  = mk(5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0, O_DIV);
        tbl[10] = mk(5'd0,  5'd0,  5'd0,  0, 0, 1, 1, 0, O_MEM);
        tbl[11] = mk(5'd0,  5'd0,  5'd0,  0, 1, 0, 1, 0, O_MEM);
        tbl[12] = mk(5'd0,  5'd0,  5'd0,  0, 1, 1, 0, 0, O_DIV);
        tbl[13] = mk(5'd31, 5'd0,  5'd31, 1, 0, 0, 1, 0, O_MEM);

        // Reset holds outputs low even with every hazard input active.
        drive(mk(5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0, O_NONE));
        #2;
        check("reset_outs", 32'(outs()), 32'(O_NONE));
        check("reset_cnt", 32'(stall_cnt_o), 0);

        foreach (tbl[i]) begin
            do_reset();
            step($sformatf("table_%0d", i), tbl[i]);
        end

        // Memory wait: three not-ready cycles then ready.
        do_reset();
        for (int i = 0; i < 3; i++) step($sformatf("memwait_%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 0, O_MEM));
        step("memwait_ready", mk(0, 0, 0, 0, 0, 0, 1, 1, O_NONE));
        step("memwait_after", mk(0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        check("memwait_cnt", 32'(stall_cnt_o), 3);

        // Divide with a branch presented throughout the busy period.
        do_reset();
        step("div_start", mk(0, 0, 0, 0, 0, 1, 0, 0, O_DIV));
        for (int i = 0; i < DL - 1; i++) step($sformatf("div_busy_%0d", i), mk(0, 0, 0, 0, 1, 0, 1, 0, O_DIV));
        step("div_done", mk(0, 0, 0, 0, 1, 0, 0, 0, O_DONE));
        step("div_branch_run", mk(0, 0, 0, 0, 1, 0, 0, 0, O_BR));
        check("div_cnt", 32'(stall_cnt_o), DL);

        // Memory wait and divide together: wait first, divide once back in RUN.
        do_reset();
        step("mix_mem0", mk(0, 0, 0, 0, 0, 1, 1, 0, O_MEM));
        step("mix_mem1", mk(0, 0, 0, 0, 0, 1, 1, 0, O_MEM));
        step("mix_ready", mk(0, 0, 0, 0, 0, 1, 1, 1, O_NONE));
        step("mix_div_start", mk(0, 0, 0, 0, 0, 1, 0, 0, O_DIV));
        for (int i = 0; i < DL - 1; i++) step($sformatf("mix_busy_%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, O_DIV));
        step("mix_done", mk(0, 0, 0, 0, 0, 0, 0, 0, O_DONE));
        step("mix_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, O_NONE));

        // Reset while the divider counter sits at 2.
        do_reset();
        step("rstdiv_start", mk(0, 0, 0, 0, 0, 1, 0, 0, O_DIV));
        step("rstdiv_busy", mk(0, 0, 0, 0, 0, 0, 0, 0, O_DIV));
        drive('0);
        rst_i = 1'b1;
        #1;
        check("rstdiv_outs", 32'(outs()), 32'(O_NONE));
        check("rstdiv_cnt", 32'(stall_cnt_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < DL + 1; i++) step($sformatf("rstdiv_quiet_%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        step("rstdiv_run_branch", mk(0, 0, 0, 0, 1, 0, 0, 0, O_BR));

        // Randomized run against the reference model; long enough to saturate the counter.
        do_reset();
        m_mem = 0; m_div_left = -1; m_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            vec_t v;
            logic r;
            logic [6:0] e;
            v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), O_NONE);
            r = (i > 400) && ($urandom_range(0, 149) == 0);
            drive(v);
            rst_i = r;
            @(negedge clk_i);
            e = r ? O_NONE : model_out(v);
            check($sformatf("rand_out_%0d", i), 32'(outs()), 32'(e));
            check($sformatf("rand_cnt_%0d", i), 32'(stall_cnt_o), r ? 0 : m_cnt);
            @(posedge clk_i);
            #1;
            model_advance(v, e, r);
        end
        rst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock `clk_i`; reset `rst_i` SHALL be asynchronous and active-high.
REQ-002 Parameter DIV_LATENCY, default 33: cycles the E-stage divider occupies; legal range 2..255.
REQ-003 Parameter CNT_W, default 32: width of the stall performance counter.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_i  in  1  async active-high reset.
REQ-006 rs1_d, rs2_d  in  5 each  source register indices of the D-stage instruction.
REQ-007 rd_e  in  5  destination register of the E-stage instruction.
REQ-008 mem_read_e  in  1  E-stage instruction is a load.
REQ-009 branch_taken_e  in  1  E-stage control transfer resolved taken.
REQ-010 div_start_e  in  1  E-stage instruction is DIV/DIVU/REM/REMU.
REQ-011 mem_req_m, mem_ready_m  in  1 each  M-stage data memory request and completion.
REQ-012 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the F, D, E and M pipeline registers.
REQ-013 flush_d, flush_e  out  1 each  load NOP into the D and E registers.
REQ-014 div_done_e  out  1  one-cycle pulse: divider result valid.
REQ-015 stall_cnt_o  out  CNT_W  count of cycles in which stall_f=1.

Function
REQ-016 The FSM SHALL have states RUN, MEM_WAIT and DIV_BUSY.
REQ-017 Load-use hazard = mem_read_e & (rd_e!=0) & (rd_e==rs1_d | rd_e==rs2_d).
REQ-018 In RUN with a load-use hazard, stall_f=stall_d=1 and flush_e=1 in the same cycle (combinational; one bubble).
REQ-019 In RUN with branch_taken_e=1, flush_d=flush_e=1 and stall_f=stall_d=0; branch SHALL take priority over load-use.
REQ-020 In RUN with mem_req_m=1 and mem_ready_m=0, stall_f/d/e/m=1 that cycle, and the FSM SHALL go to MEM_WAIT.
REQ-021 In MEM_WAIT, stall_f/d/e/m=1 until the cycle with mem_ready_m=1; in that cycle all stalls=0 and the next state is RUN.
REQ-022 In RUN with div_start_e=1 and no memory wait, stall_f/d/e=1, the counter SHALL load DIV_LATENCY-1, and the FSM SHALL go to DIV_BUSY.
REQ-023 In DIV_BUSY, stall_f/d/e=1, stall_m=0, and the counter SHALL decrement each cycle.
REQ-024 In DIV_BUSY at counter==0, all stalls=0, div_done_e=1 for exactly that cycle, and the next state is RUN; the total E occupancy is DIV_LATENCY+1 cycles.
REQ-025 When a memory wait and div_start_e occur together, the memory wait SHALL win; the held E instruction re-triggers the divide after the return to RUN.
REQ-026 Whenever stall_e=1, flush_d and flush_e SHALL be 0; a branch is honoured only once E advances.
REQ-027 div_start_e SHALL be ignored outside RUN.
REQ-028 stall_cnt_o SHALL increment when stall_f=1 and saturate at all-ones.

Reset
REQ-029 While rst_i=1: state=RUN, divide counter=0, stall_cnt_o=0, all stall/flush outputs and div_done_e=0, independent of inputs.
REQ-030 Reset mid-MEM_WAIT or mid-DIV_BUSY SHALL abort to RUN with no div_done_e pulse.

Structure
REQ-031 The state encoding and the NOP encoding constant SHALL live in the shared rv32 include/package alongside the opcodes.
REQ-032 The divide down-counter SHALL be a sub-module `lat_counter` (load, decrement, zero flag); all other logic stays flat.

Verification
REQ-033 Load-use: rd_e=5, mem_read_e=1, rs1_d=5 -> exactly one cycle of stall_f=stall_d=flush_e=1; rd_e=0 with rs1_d=0 -> no stall.
REQ-034 Branch + load-use in the same cycle: branch_taken_e=1, load-use true -> flush_d=flush_e=1, stall_f=0.
REQ-035 Memory wait: mem_req_m=1, mem_ready_m low for 3 cycles then high -> 3 cycles of all four stalls, 0 in the ready cycle, stall_cnt_o +3.
REQ-036 Divide: DIV_LATENCY=4, div_start_e pulse -> stall_e=1 for 4 cycles, div_done_e pulse in the 5th cycle, then back to RUN.
REQ-037 Branch during DIV_BUSY -> no flush until return to RUN; simultaneous mem wait and div_start -> MEM_WAIT first, then DIV_BUSY.
REQ-038 rst_i asserted mid-DIV_BUSY (counter=2) -> outputs 0 immediately, no div_done_e pulse, RUN after release.
